// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - DMCtrl request encodings (loads and stores share the size field)
//   - FSM state type
//   - size_bytes(): access size in bytes for a ctrl code
//   - is_legal():   whether a we/ctrl pair names a supported access
package lsu_pkg;

    // Load encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    // Store encodings
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        ISSUE1,
        CAPTURE,
        RSP
    } lsu_state_e;

    // Only ctrl[1:0] carries the size; ctrl[2] selects zero extension.
    function automatic logic [2:0] size_bytes(input logic [2:0] ctrl);
        case (ctrl[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] ctrl);
        case (ctrl)
            LB, LH, LW: return 1'b1;
            LBU, LHU:   return !we;  // no unsigned stores
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the load/store unit.
//   offset_i   : byte offset within the word (addr[1:0])
//   size_i     : access size in bytes (1, 2 or 4)
//   sign_ext_i : sign-extend the loaded value (LB/LH)
//   wdata_i    : right-justified store data
//   beat0_i    : read data of the first (lower) word
//   beat1_i    : read data of the second (upper) word; only matters for split loads
//   be0_o/be1_o       : byte enables of beat 0 / beat 1
//   wdata0_o/wdata1_o : lane-aligned write data of beat 0 / beat 1
//   rdata_o    : extracted and extended load data
module lsu_lane_align (
    input  logic [1:0]  offset_i,
    input  logic [2:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] beat0_i,
    input  logic [31:0] beat1_i,
    output logic [3:0]  be0_o,
    output logic [3:0]  be1_o,
    output logic [31:0] wdata0_o,
    output logic [31:0] wdata1_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  lanes;
    logic [63:0] wide;
    logic [31:0] extracted;

    // Treat the two beats as one 8-lane / 64-bit window; the upper half is beat 1.
    always_comb begin
        lanes = ((8'd1 << size_i) - 8'd1) << offset_i;
        wide  = {32'b0, wdata_i} << {offset_i, 3'b000};
    end

    assign be0_o    = lanes[3:0];
    assign be1_o    = lanes[7:4];
    assign wdata0_o = wide[31:0];
    assign wdata1_o = wide[63:32];

    always_comb begin
        extracted = 32'({beat1_i, beat0_i} >> {offset_i, 3'b000});
        case (size_i)
            3'd1:    rdata_o = {{24{sign_ext_i & extracted[7]}}, extracted[7:0]};
            3'd2:    rdata_o = {{16{sign_ext_i & extracted[15]}}, extracted[15:0]};
            default: rdata_o = extracted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a word-organised data memory with byte enables
// and 1-cycle read latency. Accepts one request at a time, splits misaligned accesses
// into two word beats and returns extended load data with a one-cycle rsp_valid_o pulse.
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   req_*                : request from the core (valid/ready handshake)
//   rsp_valid_o/err/rdata: completion pulse, illegal-ctrl flag, load data
//   mem_*                : data memory port (word address, strobes, byte enables, data)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_ctrl_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic              rsp_err_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    lsu_state_e        state_q;
    logic              we_q;
    logic [2:0]        ctrl_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] wdata_q;
    logic              split_q;
    logic [DATA_W-1:0] beat0_q;

    logic              rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_re_q, mem_we_q;
    logic [3:0]        mem_be_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              idle;
    logic [1:0]        off_w;
    logic [2:0]        size_w;
    logic [DATA_W-1:0] wdata_w;
    logic              split_w;
    logic              sign_ext;
    logic [DATA_W-1:0] beat0_w;
    logic [3:0]        be0, be1;
    logic [DATA_W-1:0] wdata0, wdata1, load_data;

    // Outputs are registered, so beat 0 is prepared from the live request while in IDLE
    // and from the latched request afterwards.
    always_comb begin
        idle     = (state_q == IDLE);
        off_w    = idle ? req_addr_i[1:0] : off_q;
        size_w   = size_bytes(idle ? req_ctrl_i : ctrl_q);
        wdata_w  = idle ? req_wdata_i : wdata_q;
        split_w  = ({2'b00, off_w} + {1'b0, size_w}) > 4'd4;
        sign_ext = !ctrl_q[2] && (ctrl_q[1:0] != 2'b10);
        // Unsplit loads see their only beat on mem_rdata_i during CAPTURE.
        beat0_w  = split_q ? beat0_q : mem_rdata_i;
    end

    lsu_lane_align u_lane_align (
        .offset_i   (off_w),
        .size_i     (size_w),
        .sign_ext_i (sign_ext),
        .wdata_i    (wdata_w),
        .beat0_i    (beat0_w),
        .beat1_i    (mem_rdata_i),
        .be0_o      (be0),
        .be1_o      (be1),
        .wdata0_o   (wdata0),
        .wdata1_o   (wdata1),
        .rdata_o    (load_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            ctrl_q      <= 3'b000;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            split_q     <= 1'b0;
            beat0_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        ctrl_q  <= req_ctrl_i;
                        off_q   <= req_addr_i[1:0];
                        wdata_q <= req_wdata_i;
                        split_q <= split_w;
                        if (!is_legal(req_we_i, req_ctrl_i)) begin
                            state_q     <= RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q     <= ISSUE0;
                            mem_addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
                            mem_re_q    <= !req_we_i;
                            mem_we_q    <= req_we_i;
                            mem_be_q    <= be0;
                            mem_wdata_q <= req_we_i ? wdata0 : '0;
                        end
                    end
                end
                ISSUE0: begin
                    if (split_q) begin
                        state_q     <= ISSUE1;
                        mem_addr_q  <= mem_addr_q + ADDR_W'(4);  // wraps at the top of memory
                        mem_be_q    <= be1;
                        mem_wdata_q <= we_q ? wdata1 : '0;
                    end else begin
                        mem_addr_q  <= '0;
                        mem_re_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= 4'b0000;
                        mem_wdata_q <= '0;
                        if (we_q) begin
                            state_q     <= RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q <= CAPTURE;
                        end
                    end
                end
                ISSUE1: begin
                    if (!we_q) beat0_q <= mem_rdata_i;
                    mem_addr_q  <= '0;
                    mem_re_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_be_q    <= 4'b0000;
                    mem_wdata_q <= '0;
                    if (we_q) begin
                        state_q     <= RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end else begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state_q     <= RSP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= load_data;
                end
                RSP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = idle;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_re_o    = mem_re_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural word memory on the mem port,
// byte-addressed reference model for expected load data, directed plus random requests.
module tb_load_store_unit;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr;
    logic        mem_re, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_ctrl_i  (req_ctrl),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_err_o   (rsp_err),
        .rsp_rdata_o (rsp_rdata),
        .mem_addr_o  (mem_addr),
        .mem_re_o    (mem_re),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: 256 words, byte enables, 1-cycle read latency.
    logic [31:0] dmem [0:255] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_we)
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) dmem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        if (mem_re) mem_rdata <= dmem[mem_addr[9:2]];
    end

    // Reference model: plain byte array, same 1 KiB aliasing as dmem.
    logic [7:0] ref_b [0:1023];

    function automatic int size_of(input logic [2:0] ctrl);
        case (ctrl[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit illegal(input logic we, input logic [2:0] ctrl);
        return (ctrl == 3'b011) || (ctrl[2:1] == 2'b11) || (we && ctrl[2]);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] ctrl, input logic [31:0] addr);
        logic [31:0] v, a;
        int n;
        n = size_of(ctrl);
        v = 0;
        for (int i = 0; i < n; i++) begin
            a = addr + i;
            v = v | (32'(ref_b[a[9:0]]) << (8 * i));
        end
        if (ctrl == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
        if (ctrl == 3'b001 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] ctrl, input logic [31:0] addr,
                             input logic [31:0] data);
        logic [31:0] a;
        for (int i = 0; i < size_of(ctrl); i++) begin
            a = addr + i;
            ref_b[a[9:0]] = data[8*i +: 8];
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [31:0] a;
        logic [31:0] v;
        v = 0;
        for (int i = 0; i < 4; i++) begin
            a = addr + i;
            v[8*i +: 8] = ref_b[a[9:0]];
        end
        return v;
    endfunction

    function automatic int exp_lat(input logic we, input logic [2:0] ctrl,
                                   input logic [31:0] addr);
        bit split;
        if (illegal(we, ctrl)) return 1;
        split = (int'(addr[1:0]) + size_of(ctrl)) > 4;
        if (we) return split ? 3 : 2;
        return split ? 4 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // Per-transaction capture
    logic [31:0] b_addr [2];
    logic [31:0] b_wdata [2];
    logic [3:0]  b_be [2];
    logic        b_we [2];
    int          nbeats;
    logic [31:0] x_rdata;
    logic        x_err;
    int          x_lat;

    task automatic xact(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_ctrl  = ctrl;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        // Scramble the request fields: the unit must use its latched copy.
        req_valid = 1'b0;
        req_we    = ~we;
        req_ctrl  = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        x_lat   = -1;
        x_rdata = 32'hx;
        x_err   = 1'bx;
        nbeats  = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("strobe_excl", 32'(mem_re & mem_we), 32'd0);
            if (!mem_re && !mem_we) chk("be_idle", 32'(mem_be), 32'd0);
            else if (nbeats < 2) begin
                b_addr[nbeats]  = mem_addr;
                b_wdata[nbeats] = mem_wdata;
                b_be[nbeats]    = mem_be;
                b_we[nbeats]    = mem_we;
                nbeats++;
            end
            if (rsp_valid) begin
                x_lat   = c;
                x_rdata = rsp_rdata;
                x_err   = rsp_err;
                break;
            end
        end
        chk("latency", 32'(x_lat), 32'(exp_lat(we, ctrl, addr)));
    endtask

    // Full request with model-derived checks on err/rdata/latency.
    task automatic run(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                       input logic [31:0] wdata);
        logic [31:0] exp_rd;
        bit bad;
        bad    = illegal(we, ctrl);
        exp_rd = (bad || we) ? 32'h0 : ref_load(ctrl, addr);
        xact(we, ctrl, addr, wdata);
        chk("rsp_err", 32'(x_err), 32'(bad));
        chk("rsp_rdata", x_rdata, exp_rd);
        if (!bad && we) ref_store(ctrl, addr, wdata);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_b[i] = 8'h00;
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_ctrl = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;

        // Reset state
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // 1: aligned word store/load
        run(1'b1, 3'b010, 32'h0, 32'hDEADBEEF);
        chk("t1_nbeats", 32'(nbeats), 32'd1);
        chk("t1_be", 32'(b_be[0]), 32'hF);
        chk("t1_we", 32'(b_we[0]), 32'd1);
        chk("t1_wdata", b_wdata[0], 32'hDEADBEEF);
        run(1'b0, 3'b010, 32'h0, 32'h0);
        chk("t1_lw_const", x_rdata, 32'hDEADBEEF);

        // 2: halfwords
        run(1'b1, 3'b001, 32'h8, 32'h0000ABCA);
        chk("t2_be", 32'(b_be[0]), 32'h3);
        run(1'b0, 3'b001, 32'h8, 32'h0);
        chk("t2_lh_const", x_rdata, 32'hFFFFABCA);
        run(1'b0, 3'b101, 32'h8, 32'h0);
        chk("t2_lhu_const", x_rdata, 32'h0000ABCA);

        // 3: bytes
        run(1'b1, 3'b000, 32'h10, 32'h00000080);
        run(1'b0, 3'b000, 32'h10, 32'h0);
        chk("t3_lb_const", x_rdata, 32'hFFFFFF80);
        run(1'b0, 3'b100, 32'h10, 32'h0);
        chk("t3_lbu_const", x_rdata, 32'h00000080);
        run(1'b0, 3'b100, 32'h3, 32'h0);
        chk("t3_lbu3_const", x_rdata, 32'h000000DE);

        // 4: misaligned word store and loads
        run(1'b1, 3'b010, 32'h21, 32'h11223344);
        chk("t4_nbeats", 32'(nbeats), 32'd2);
        chk("t4_b0_addr", b_addr[0], 32'h20);
        chk("t4_b0_be", 32'(b_be[0]), 32'hE);
        chk("t4_b0_wdata", b_wdata[0], 32'h22334400);
        chk("t4_b1_addr", b_addr[1], 32'h24);
        chk("t4_b1_be", 32'(b_be[1]), 32'h1);
        chk("t4_b1_wdata", b_wdata[1], 32'h00000011);
        run(1'b0, 3'b010, 32'h21, 32'h0);
        chk("t4_lw_const", x_rdata, 32'h11223344);
        run(1'b0, 3'b001, 32'h23, 32'h0);

        // 5: illegal requests
        run(1'b0, 3'b011, 32'h40, 32'h0);
        chk("t5_ld_nbeats", 32'(nbeats), 32'd0);
        run(1'b1, 3'b100, 32'h44, 32'h12345678);
        chk("t5_st_nbeats", 32'(nbeats), 32'd0);

        // 6: reset during beat 1 of a split store
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_ctrl  = 3'b010;
        req_addr  = 32'h21;
        req_wdata = 32'h55667788;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_issue1_we", 32'(mem_we), 32'd1);
        chk("t6_issue1_addr", mem_addr, 32'h24);
        rst = 1'b1;
        #1;
        chk("t6_rst_we", 32'(mem_we), 32'd0);
        chk("t6_rst_be", 32'(mem_be), 32'd0);
        ref_store(3'b001, 32'h21, 32'h00007788);  // beat 0 lanes 1..3 already committed
        ref_b[10'h23] = 8'h66;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t6_ready", 32'(req_ready), 32'd1);
        chk("t6_word24", dmem[9], ref_word(32'h24));
        chk("t6_word24_const", dmem[9], 32'h00000011);
        chk("t6_word20", dmem[8], ref_word(32'h20));
        run(1'b0, 3'b010, 32'h0, 32'h0);
        chk("t6_lw0_const", x_rdata, 32'hDEADBEEF);
        run(1'b0, 3'b010, 32'h21, 32'h0);

        // Address wrap on beat 1
        run(1'b1, 3'b010, 32'hFFFFFFFD, 32'hA1B2C3D4);
        chk("wrap_b0_addr", b_addr[0], 32'hFFFFFFFC);
        chk("wrap_b1_addr", b_addr[1], 32'h00000000);
        run(1'b0, 3'b010, 32'hFFFFFFFD, 32'h0);
        chk("wrap_lw_const", x_rdata, 32'hA1B2C3D4);

        // Random traffic against the byte model
        for (int k = 0; k < 80; k++) begin
            logic [2:0]  c;
            logic [31:0] a;
            c = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
            if (c == 3'b011) c = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b010;
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                            : 32'($urandom_range(0, 63));
            run(1'($urandom), c, a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
